execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
//  Pipeline stage directly downstream of decode; consumes its registered ALU, branch, write-back and load-store fields.
//  Computes the ALU result and resolves conditional and unconditional branches.
//  Registers the result with write-back and load-store pass-through fields for the load-store stage.
//  Drives a registered branch request (taken flag and target) to fetch and the hazard unit.
// PARAMETERS
//  none; ALU_*, BRANCH_* and NO_BRANCH encodings come from ecap5_dproc_pkg
// PORTS
//  clk_i               in   1   clock; all state updates on posedge
//  rst_i               in   1   reset, synchronous, active-high
//  input_ready_o       out  1   stage can accept; = output_ready_i (combinational)
//  input_valid_i       in   1   decode fields valid
//  pc_i                in   32  pc of instruction
//  alu_operand1_i      in   32  op1 (rs1 or pc)
//  alu_operand2_i      in   32  op2 (rs2 or immediate)
//  alu_op_i            in   3   ALU_ADD/SLT/SLTU/XOR/OR/AND/SHIFT
//  alu_sub_i           in   1   ALU_ADD performs op1-op2
//  alu_shift_left_i    in   1   shift direction left
//  alu_signed_shift_i  in   1   right shift is arithmetic
//  branch_cond_i       in   3   NO_BRANCH/BRANCH_BEQ..BGEU/BRANCH_UNCOND
//  branch_offset_i     in   20  conditional branch offset, signed
//  reg_write_i         in   1   write-back enable
//  reg_addr_i          in   5   destination register
//  ls_enable_i, ls_write_i, ls_unsigned_load_i  in  1 each   load-store controls
//  ls_write_data_i     in   32  store data
//  ls_sel_i            in   4   byte select
//  output_ready_i      in   1   load-store stage can accept
//  output_valid_o      out  1   outputs valid
//  result_o            out  32  ALU result / link address / memory address
//  reg_write_o, reg_addr_o, ls_*_o  out  as inputs   registered pass-through
//  branch_o            out  1   branch taken; one cycle per accepted instruction
//  branch_target_o     out  32  branch destination
// BEHAVIOUR
//  - Reset: every output register is 0; branch_o=0, output_valid_o=0.
//  - One register stage, latency 1 cycle.
//  - Update rule: registers update only when output_ready_i=1; otherwise every output holds.
//  - Valid: when output_ready_i=1, output_valid_o<=input_valid_i.
//  - Invalid accept: an invalid input loads reg_write=0, ls_enable=0 and branch_o=0.
//  - ALU arithmetic is 32-bit and wraps on overflow.
//    - ADD: op1+op2, or op1-op2 when alu_sub_i=1.
//    - SLT: signed compare; SLTU: unsigned compare; both give {31'b0,lt}.
//    - SHIFT: shamt=op2[4:0]; sll / srl / sra selected by alu_shift_left_i and alu_signed_shift_i.
//  - BRANCH_UNCOND (JAL/JALR):
//    - result = pc_i+4.
//    - target = (op1+op2) & ~32'h1.
//    - taken=1.
//  - Conditional branches:
//    - eq/ne/lt/ge/ltu/geu of op1 vs op2.
//    - target = pc_i + sext32(branch_offset_i).
//    - result = ALU output.
//  - NO_BRANCH: taken=0; branch_target_o still loaded but ignored.
//  - branch_o is a single-cycle pulse aligned with output_valid_o.
//    - With output_ready_i=0 it holds, and is counted once by consumers on the valid+ready cycle.
//  - Flushing wrong-path instructions is done by the hazard unit via input_valid_i; execute does not squash.
//  - Reset mid-operation: outputs clear next edge and any in-flight instruction is dropped.
// CONFIGURATION
//  EXECUTE_MISALIGN_EXC_EN
//  - defined: adds output misaligned_o (1 bit, reset 0).
//    - Taken branch with target[1]=1: branch_o=0, misaligned_o=1, reg_write_o=0.
//  - undefined: no port; target[1] is ignored.
// TESTING
//  1. Reset: rst_i=1 for 2 cycles -> every output 0 incl. output_valid_o and branch_o.
//  2. ADD with sub and SRA:
//     - op1=5, op2=7, ALU_ADD, sub=1 -> result_o=32'hFFFFFFFE, output_valid_o=1 next cycle.
//     - op1=32'h80000000, op2=4, SHIFT, signed -> result_o=32'hF8000000.
//  3. BEQ op1=op2=3, pc=32'h100, offset=20'hFFFF8 -> branch_o=1, branch_target_o=32'hF8, branch_o=0 next cycle.
//  4. JALR op1=32'h1001, op2=4, pc=32'h200, UNCOND -> result_o=32'h204, target=32'h1004, branch_o=1.
//  5. Backpressure: output_ready_i=0 for 3 cycles after a valid accept -> outputs frozen, input_ready_o=0, no extra branch pulse.
//  6. Misalignment and invalid input:
//     - With EXECUTE_MISALIGN_EXC_EN, JAL pc=0, op2=6 -> misaligned_o=1, branch_o=0.
//     - input_valid_i=0 -> reg_write_o=0, output_valid_o=0.

Source files
------------

// File: rtl/execute.sv
// execute: ALU, branch resolution and the registered hand-off from decode to load-store.
// Optional EXECUTE_MISALIGN_EXC_EN adds misaligned_o for taken branches whose target has bit 1 set.
package ecap5_dproc_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SLT = 3'd1, ALU_SLTU = 3'd2, ALU_XOR = 3'd3,
                           ALU_OR = 3'd4, ALU_AND = 3'd5, ALU_SHIFT = 3'd6;
    localparam logic [2:0] NO_BRANCH = 3'd0, BRANCH_BEQ = 3'd1, BRANCH_BNE = 3'd2, BRANCH_BLT = 3'd3,
                           BRANCH_BGE = 3'd4, BRANCH_BLTU = 3'd5, BRANCH_BGEU = 3'd6, BRANCH_UNCOND = 3'd7;
endpackage

module execute
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_operand1_i,
    input  logic [31:0] alu_operand2_i,
    input  logic [2:0]  alu_op_i,
    input  logic        alu_sub_i,
    input  logic        alu_shift_left_i,
    input  logic        alu_signed_shift_i,
    input  logic [2:0]  branch_cond_i,
    input  logic [19:0] branch_offset_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic        ls_unsigned_load_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] result_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic        ls_enable_o,
    output logic        ls_write_o,
    output logic        ls_unsigned_load_o,
    output logic [31:0] ls_write_data_o,
    output logic [3:0]  ls_sel_o,
`ifdef EXECUTE_MISALIGN_EXC_EN
    output logic        misaligned_o,
`endif
    output logic        branch_o,
    output logic [31:0] branch_target_o
);
    logic [31:0] op1, op2, shifted, alu, target, result;
    logic [4:0]  shamt;
    logic        eq, lt, ltu, taken, mis;

    assign input_ready_o = output_ready_i;
    assign op1 = alu_operand1_i;
    assign op2 = alu_operand2_i;

    always_comb begin
        shamt   = op2[4:0];
        eq      = op1 == op2;
        lt      = $signed(op1) < $signed(op2);
        ltu     = op1 < op2;
        shifted = alu_shift_left_i ? op1 << shamt :
                  alu_signed_shift_i ? $unsigned($signed(op1) >>> shamt) : op1 >> shamt;
        alu     = alu_op_i == ALU_ADD   ? (alu_sub_i ? op1 - op2 : op1 + op2) :
                  alu_op_i == ALU_SLT   ? {31'b0, lt} :
                  alu_op_i == ALU_SLTU  ? {31'b0, ltu} :
                  alu_op_i == ALU_XOR   ? op1 ^ op2 :
                  alu_op_i == ALU_OR    ? op1 | op2 :
                  alu_op_i == ALU_AND   ? op1 & op2 :
                  alu_op_i == ALU_SHIFT ? shifted : 32'b0;
        taken   = branch_cond_i == BRANCH_UNCOND
                | (branch_cond_i == BRANCH_BEQ  &  eq)
                | (branch_cond_i == BRANCH_BNE  & ~eq)
                | (branch_cond_i == BRANCH_BLT  &  lt)
                | (branch_cond_i == BRANCH_BGE  & ~lt)
                | (branch_cond_i == BRANCH_BLTU &  ltu)
                | (branch_cond_i == BRANCH_BGEU & ~ltu);
        target  = branch_cond_i == BRANCH_UNCOND ? (op1 + op2) & ~32'h1
                                                 : pc_i + {{12{branch_offset_i[19]}}, branch_offset_i};
        result  = branch_cond_i == BRANCH_UNCOND ? pc_i + 32'd4 : alu;
    end

`ifdef EXECUTE_MISALIGN_EXC_EN
    assign mis = input_valid_i & taken & target[1];
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            output_valid_o     <= 1'b0;
            result_o           <= 32'b0;
            reg_write_o        <= 1'b0;
            reg_addr_o         <= 5'b0;
            ls_enable_o        <= 1'b0;
            ls_write_o         <= 1'b0;
            ls_unsigned_load_o <= 1'b0;
            ls_write_data_o    <= 32'b0;
            ls_sel_o           <= 4'b0;
            branch_o           <= 1'b0;
            branch_target_o    <= 32'b0;
`ifdef EXECUTE_MISALIGN_EXC_EN
            misaligned_o       <= 1'b0;
`endif
        end else if (output_ready_i) begin
            output_valid_o     <= input_valid_i;
            result_o           <= result;
            reg_write_o        <= input_valid_i & reg_write_i & ~mis;
            reg_addr_o         <= reg_addr_i;
            ls_enable_o        <= input_valid_i & ls_enable_i;
            ls_write_o         <= ls_write_i;
            ls_unsigned_load_o <= ls_unsigned_load_i;
            ls_write_data_o    <= ls_write_data_i;
            ls_sel_o           <= ls_sel_i;
            branch_o           <= input_valid_i & taken & ~mis;
            branch_target_o    <= target;
`ifdef EXECUTE_MISALIGN_EXC_EN
            misaligned_o       <= mis;
`endif
        end
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed and random stimulus for execute against a behavioural scoreboard.
module tb_execute;
    import ecap5_dproc_pkg::*;

    logic clk = 0, rst = 1;
    logic in_valid = 0, sub = 0, shl = 0, sgn = 0, rw = 0, lse = 0, lsw = 0, lsu = 0, ready = 1;
    logic [31:0] pc = 0, op1 = 0, op2 = 0, wdata = 0;
    logic [2:0] aop = 0, bcond = 0;
    logic [19:0] boff = 0;
    logic [4:0] raddr = 0;
    logic [3:0] sel = 0;
    logic in_ready, out_valid, rw_o, lse_o, lsw_o, lsu_o, br_o, mis_o;
    logic [31:0] res_o, wdata_o, tgt_o;
    logic [4:0] raddr_o;
    logic [3:0] sel_o;

    execute dut (
        .clk_i(clk), .rst_i(rst), .input_ready_o(in_ready), .input_valid_i(in_valid), .pc_i(pc),
        .alu_operand1_i(op1), .alu_operand2_i(op2), .alu_op_i(aop), .alu_sub_i(sub),
        .alu_shift_left_i(shl), .alu_signed_shift_i(sgn), .branch_cond_i(bcond),
        .branch_offset_i(boff), .reg_write_i(rw), .reg_addr_i(raddr), .ls_enable_i(lse),
        .ls_write_i(lsw), .ls_unsigned_load_i(lsu), .ls_write_data_i(wdata), .ls_sel_i(sel),
        .output_ready_i(ready), .output_valid_o(out_valid), .result_o(res_o), .reg_write_o(rw_o),
        .reg_addr_o(raddr_o), .ls_enable_o(lse_o), .ls_write_o(lsw_o), .ls_unsigned_load_o(lsu_o),
        .ls_write_data_o(wdata_o), .ls_sel_o(sel_o),
`ifdef EXECUTE_MISALIGN_EXC_EN
        .misaligned_o(mis_o),
`endif
        .branch_o(br_o), .branch_target_o(tgt_o)
    );
`ifndef EXECUTE_MISALIGN_EXC_EN
    assign mis_o = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    // scoreboard image of the output registers
    logic e_valid = 0, e_rw = 0, e_lse = 0, e_lsw = 0, e_lsu = 0, e_br = 0, e_mis = 0;
    logic [31:0] e_res = 0, e_wdata = 0, e_tgt = 0;
    logic [4:0] e_raddr = 0;
    logic [3:0] e_sel = 0;
    bit check_tgt = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        logic [31:0] alu, tgt, res;
        bit taken, misal;
        int a, b;
        a = int'(op1);
        b = int'(op2);
        case (aop)
            ALU_ADD:   alu = sub ? op1 - op2 : op1 + op2;
            ALU_SLT:   alu = (a < b) ? 1 : 0;
            ALU_SLTU:  alu = (longint'({32'b0, op1}) < longint'({32'b0, op2})) ? 1 : 0;
            ALU_XOR:   alu = op1 ^ op2;
            ALU_OR:    alu = op1 | op2;
            ALU_AND:   alu = op1 & op2;
            ALU_SHIFT: alu = shl ? op1 << op2[4:0] : sgn ? 32'(a >>> op2[4:0]) : op1 >> op2[4:0];
            default:   alu = 0;
        endcase
        case (bcond)
            BRANCH_BEQ:  taken = op1 == op2;
            BRANCH_BNE:  taken = op1 != op2;
            BRANCH_BLT:  taken = a < b;
            BRANCH_BGE:  taken = a >= b;
            BRANCH_BLTU: taken = longint'({32'b0, op1}) < longint'({32'b0, op2});
            BRANCH_BGEU: taken = longint'({32'b0, op1}) >= longint'({32'b0, op2});
            BRANCH_UNCOND: taken = 1;
            default:     taken = 0;
        endcase
        if (bcond == BRANCH_UNCOND) begin
            res = pc + 4;
            tgt = 32'(longint'(op1) + longint'(op2)) & 32'hFFFF_FFFE;
        end else begin
            res = alu;
            tgt = 32'(int'(pc) + (int'({boff, 12'b0}) >>> 12));
        end
`ifdef EXECUTE_MISALIGN_EXC_EN
        misal = in_valid && taken && tgt[1];
`else
        misal = 0;
`endif
        e_valid = in_valid;
        e_res = res;
        e_rw = in_valid && rw && !misal;
        e_raddr = raddr;
        e_lse = in_valid && lse;
        e_lsw = lsw;
        e_lsu = lsu;
        e_wdata = wdata;
        e_sel = sel;
        e_br = in_valid && taken && !misal;
        e_tgt = tgt;
        e_mis = misal;
        check_tgt = bcond != NO_BRANCH;
    endtask

    task automatic check_all();
        chk("input_ready", in_ready, ready);
        chk("output_valid", out_valid, e_valid);
        chk("result", res_o, e_res);
        chk("reg_write", rw_o, e_rw);
        chk("reg_addr", raddr_o, e_raddr);
        chk("ls_enable", lse_o, e_lse);
        chk("ls_write", lsw_o, e_lsw);
        chk("ls_unsigned", lsu_o, e_lsu);
        chk("ls_wdata", wdata_o, e_wdata);
        chk("ls_sel", sel_o, e_sel);
        chk("branch", br_o, e_br);
        chk("misaligned", mis_o, e_mis);
        if (check_tgt) chk("branch_target", tgt_o, e_tgt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            {e_valid, e_rw, e_lse, e_lsw, e_lsu, e_br, e_mis} = '0;
            {e_res, e_wdata, e_tgt, e_raddr, e_sel} = '0;
            check_tgt = 1;
        end else if (ready) predict();
        #1;
        check_all();
    endtask

    task automatic set_op(logic [2:0] c, logic [2:0] o, logic [31:0] p, logic [31:0] a, logic [31:0] b);
        in_valid = 1; bcond = c; aop = o; pc = p; op1 = a; op2 = b;
        sub = 0; shl = 0; sgn = 0; boff = 0; rw = 1; raddr = 5'd3; lse = 0;
    endtask

    task automatic rand_in();
        in_valid = $urandom_range(0, 9) < 8;
        pc = $urandom & 32'hFFFF_FFFC;
        op1 = $urandom;
        op2 = ($urandom_range(0, 3) == 0) ? op1 : $urandom;
        if ($urandom_range(0, 3) == 0) op2 = {27'b0, op2[4:0]};
        aop = 3'($urandom_range(0, 6));
        bcond = 3'($urandom_range(0, 7));
        boff = 20'($urandom);
        {sub, shl, sgn, rw, lse, lsw, lsu} = 7'($urandom);
        raddr = 5'($urandom);
        wdata = $urandom;
        sel = 4'($urandom);
    endtask

    initial begin
        // reset held two cycles
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_branch", br_o, 0);
        #2 rst = 0;

        set_op(NO_BRANCH, ALU_ADD, 0, 5, 7); sub = 1;
        tick();
        chk("sub_result", res_o, 32'hFFFF_FFFE);
        chk("sub_valid", out_valid, 1);
        #2 set_op(NO_BRANCH, ALU_SHIFT, 0, 32'h8000_0000, 4); sgn = 1;
        tick();
        chk("sra_result", res_o, 32'hF800_0000);

        #2 set_op(BRANCH_BEQ, ALU_ADD, 32'h100, 3, 3); boff = 20'hFFFF8;
        tick();
        chk("beq_taken", br_o, 1);
        chk("beq_target", tgt_o, 32'h0000_00F8);
        #2 set_op(NO_BRANCH, ALU_OR, 0, 1, 2);
        tick();
        chk("beq_pulse_end", br_o, 0);

        #2 set_op(BRANCH_UNCOND, ALU_ADD, 32'h200, 32'h1001, 4);
        tick();
        chk("jalr_result", res_o, 32'h204);
        chk("jalr_target", tgt_o, 32'h1004);
        chk("jalr_taken", br_o, 1);

        // backpressure right after a taken accept: everything frozen
        #2 ready = 0;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            tick();
            chk("bp_ready", in_ready, 0);
            chk("bp_result", res_o, 32'h204);
            chk("bp_branch", br_o, 1);
            #2;
        end
        ready = 1;

        set_op(BRANCH_UNCOND, ALU_ADD, 0, 0, 6);
        tick();
`ifdef EXECUTE_MISALIGN_EXC_EN
        chk("mis_flag", mis_o, 1);
        chk("mis_branch", br_o, 0);
        chk("mis_rw", rw_o, 0);
`else
        chk("jal_taken", br_o, 1);
        chk("jal_target", tgt_o, 32'h6);
`endif
        #2 set_op(BRANCH_UNCOND, ALU_ADD, 0, 0, 8); in_valid = 0;
        tick();
        chk("inv_rw", rw_o, 0);
        chk("inv_valid", out_valid, 0);
        chk("inv_branch", br_o, 0);

        for (int i = 0; i < 400; i++) begin
            #2 rand_in();
            ready = $urandom_range(0, 3) != 0;
            rst = (i == 200);
            tick();
        end
        #2 rst = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
